// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared widths and FSM state type for the 32/16 sequential divider
package seq_divider_pkg;

   localparam int DIVIDEND_W = 32;
   localparam int DIVISOR_W  = 16;
   localparam int ITER_N     = 32;
   localparam int CNT_W      = $clog2(ITER_N);
   // One guard bit above the divisor width keeps the shifted compare exact
   localparam int PREM_W     = DIVISOR_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/seq_divider_32by16_div_step.sv
// rtl/seq_divider_32by16_div_step.sv - one radix-2 restoring shift/compare/subtract step
module div_step
   import seq_divider_pkg::*;
(
   input  logic [PREM_W-1:0]    prem_in,
   input  logic                 bit_in,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [PREM_W-1:0]    prem_out,
   output logic                 q_bit
);

   logic [PREM_W:0] shifted;

   always_comb begin
      shifted  = {prem_in, bit_in};
      q_bit    = (shifted >= (PREM_W+1)'(divisor));
      prem_out = PREM_W'(q_bit ? (shifted - (PREM_W+1)'(divisor)) : shifted);
   end

endmodule

// File: rtl/seq_divider_32by16.sv
// rtl/seq_divider_32by16.sv - 32/16 unsigned sequential restoring divider, valid/ready handshake
// Optional: SEQ_DIVIDER_DIV_ZERO_EN adds div_zero and a one-cycle zero-divisor shortcut.
module seq_divider_32by16
   import seq_divider_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_sync,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
   ,
   output logic                  div_zero
`endif
);

   div_state_e state;
   div_state_e next_state;

   logic [DIVIDEND_W-1:0] dvd_q;
   logic [DIVISOR_W-1:0]  dvs_q;
   logic [PREM_W-1:0]     prem_q;
   logic [DIVIDEND_W-1:0] quo_q;
   logic [CNT_W-1:0]      cnt_q;

   logic [PREM_W-1:0]     step_prem;
   logic                  step_qbit;
   logic                  accept;
   logic                  last_step;
   logic                  zero_fast;

`ifdef SEQ_DIVIDER_DIV_ZERO_EN
   logic div_zero_q;
   assign zero_fast = (divisor == '0);
   assign div_zero  = div_zero_q;
`else
   assign zero_fast = 1'b0;
`endif

   assign accept    = in_valid && in_ready;
   assign last_step = (cnt_q == CNT_W'(ITER_N - 1));
   assign quotient  = quo_q;
   assign remainder = prem_q[DIVISOR_W-1:0];

   div_step u_div_step (
      .prem_in  (prem_q),
      .bit_in   (dvd_q[DIVIDEND_W-1]),
      .divisor  (dvs_q),
      .prem_out (step_prem),
      .q_bit    (step_qbit)
   );

   always_ff @(posedge clk) begin
      if (rst_sync) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               next_state = zero_fast ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (last_step) begin
               next_state = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Dividend register doubles as the MSB-first bit source for the step.
   // A zero divisor needs no special case in the iterative path: every step
   // yields a 1 and the partial remainder ends up holding the dividend's low bits.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         dvd_q  <= '0;
         dvs_q  <= '0;
         prem_q <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
         div_zero_q <= 1'b0;
`endif
      end else if (accept) begin
         dvd_q <= dividend;
         dvs_q <= divisor;
         cnt_q <= '0;
         if (zero_fast) begin
            quo_q  <= '1;
            prem_q <= {1'b0, dividend[DIVISOR_W-1:0]};
         end else begin
            prem_q <= '0;
         end
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
         div_zero_q <= zero_fast;
`endif
      end else if (state == BUSY) begin
         dvd_q  <= {dvd_q[DIVIDEND_W-2:0], 1'b0};
         prem_q <= step_prem;
         quo_q  <= {quo_q[DIVIDEND_W-2:0], step_qbit};
         cnt_q  <= cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_seq_divider_32by16.sv
// tb/tb_seq_divider_32by16.sv - scoreboard bench for seq_divider_32by16 (directed + random)
`timescale 1ns/1ps
module tb_seq_divider_32by16;

   logic        clk = 1'b0;
   logic        rst_sync = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] quotient;
   logic [15:0] remainder;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
   logic        div_zero;
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] q;
      logic [15:0] r;
      logic        dz;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   rdy_mode = 0;
   logic        prev_valid = 1'b0;
   logic [31:0] held_q;
   logic [15:0] held_r;

   seq_divider_32by16 dut (
      .clk       (clk),
      .rst_sync  (rst_sync),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder)
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
      ,
      .div_zero  (div_zero)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
      exp_t e;
      if (b == 0) begin
         e.q  = 32'hFFFF_FFFF;
         e.r  = a[15:0];
         e.dz = DZ_EN;
         e.lat = DZ_EN ? 1 : 32;
      end else begin
         e.q  = a / {16'h0, b};
         e.r  = 16'(a % {16'h0, b});
         e.dz = 1'b0;
         e.lat = 32;
      end
      e.acc = 0;
      return e;
   endfunction

   // out_ready driver: random, held low, or held high
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1:       out_ready = 1'b0;
            2:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: latency on rise, stability while held, compare on hand-off
   always @(negedge clk) begin
      if (rst_sync) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid) begin
            if (!prev_valid) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_result quotient=%0h remainder=%0h with empty scoreboard", quotient, remainder);
               end else begin
                  chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
               end
               held_q = quotient;
               held_r = remainder;
            end else begin
               chk("hold_quotient", quotient, held_q);
               chk("hold_remainder", remainder, held_r);
            end
            chk("in_ready_while_done", in_ready, 1'b0);
            if (out_ready && sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
               chk("div_zero", div_zero, e.dz);
`endif
            end
         end
         prev_valid = out_valid && !out_ready;
      end
   end

   task automatic issue(input logic [31:0] a, input logic [15:0] b, input bit noise);
      exp_t e;
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL issue_timeout in_ready=%0b required=1", in_ready);
         return;
      end
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      e = model(a, b);
      e.acc = cyc;
      sb.push_back(e);
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = 16'($urandom);
      if (noise && !(DZ_EN && b == 0)) begin
         repeat (8) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            dividend = $urandom;
            divisor  = 16'($urandom);
         end
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() > 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [15:0] b;
      int t;
      repeat (3) @(posedge clk);
      #1 rst_sync = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_quotient", quotient, 32'h0);
      chk("reset_remainder", remainder, 16'h0);

      rdy_mode = 2;
      issue(32'd100, 16'd7, 1'b1);
      wait_drain();
      issue(32'hFFFF_FFFF, 16'hFFFF, 1'b1);
      issue(32'hFFFF_FFFF, 16'h0001, 1'b1);
      issue(32'h1234_5678, 16'h0000, 1'b1);
      issue(32'h0000_0000, 16'h0005, 1'b1);
      issue(32'h0000_FFFF, 16'h0000, 1'b0);
      wait_drain();

      // Hold the result for 10 cycles, then hand off
      rdy_mode = 1;
      issue(32'd100, 16'd7, 1'b0);
      t = 0;
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("hold_reached_done", out_valid, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_out_valid", out_valid, 1'b1);
         chk("hold_in_ready", in_ready, 1'b0);
         chk("hold_q_value", quotient, 32'd14);
         chk("hold_r_value", remainder, 16'd2);
      end
      rdy_mode = 2;
      @(negedge clk);
      @(negedge clk);
      chk("after_handoff_in_ready", in_ready, 1'b1);
      chk("after_handoff_out_valid", out_valid, 1'b0);
      chk("handoff_popped", 64'(sb.size()), 64'd0);

      // Reset in the middle of BUSY aborts without a result
      issue(32'hDEAD_BEEF, 16'h0123, 1'b0);
      repeat (9) @(posedge clk);
      #1 rst_sync = 1'b1;
      @(posedge clk);
      #1 rst_sync = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_in_ready", in_ready, 1'b1);
      chk("abort_quotient", quotient, 32'h0);
      issue(32'd50, 16'd5, 1'b0);
      wait_drain();

      // Random operands with random back-pressure
      rdy_mode = 0;
      for (int n = 0; n < 1000; n++) begin
         case ($urandom_range(0, 9))
            0:       b = 16'h0000;
            1:       b = 16'h0001;
            2:       b = 16'hFFFF;
            3:       b = 16'($urandom_range(1, 15));
            default: b = 16'($urandom);
         endcase
         a = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
         issue(a, b, 1'($urandom));
      end
      rdy_mode = 2;
      wait_drain();
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
